// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Four requesters share a single 1-bit channel. Grants rotate round-robin,
// and each grant is capped at HOLD_MAX consecutive cycles so that no
// requester can starve the others. gnt, s and busy are registered. y is a
// combinational 4:1 mux gated by busy.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       y
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hcnt;

  logic [1:0] next_ptr;
  logic [1:0] arb_base;
  logic       win_found;
  logic [1:0] win_idx;

  // Returns {found, index} of the first set bit of r, scanning from base
  // upward (mod 4). The scan runs from lowest to highest priority so that
  // the highest-priority hit is the last one written.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // From IDLE, arbitrate from the current pointer. From GRANT, arbitrate from
  // the slot after the holder, which puts the holder last in line.
  always_comb begin
    next_ptr             = s + 2'd1;
    arb_base             = (state == IDLE) ? ptr : next_ptr;
    {win_found, win_idx} = pick(req, arb_base);
  end

  // Grant FSM: load a winner, keep the holder until it releases or its hold
  // budget runs out, then hand over with no idle bubble when someone waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      s     <= 2'b00;
      busy  <= 1'b0;
      ptr   <= 2'b00;
      hcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win_idx;
            s     <= win_idx;
            busy  <= 1'b1;
            hcnt  <= 4'd1;
          end else begin
            gnt  <= 4'b0000;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (req[s] && (hcnt < HOLD_LIM)) begin
            hcnt <= hcnt + 4'd1;
          end else begin
            ptr <= next_ptr;
            if (win_found) begin
              gnt  <= 4'b0001 << win_idx;
              s    <= win_idx;
              busy <= 1'b1;
              hcnt <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              busy  <= 1'b0;
              hcnt  <= 4'd0;
            end
          end
        end
      endcase
    end
  end

  assign y = busy & i[s];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. Three instances (HOLD_MAX = 4, 2 and 1)
// share the same stimulus. The HOLD_MAX=4 instance is first driven through a
// table of directed vectors with hand-derived results. Then all instances are
// compared against a behavioural reference model, through several
// hand-written corner sequences and a randomized run.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i;

  logic [3:0] gnt4, gnt2, gnt1;
  logic [1:0] s4, s2, s1;
  logic       busy4, busy2, busy1;
  logic       y4, y2, y1;

  logic [7:0] o4, o2, o1;
  assign o4 = {gnt4, s4, busy4, y4};
  assign o2 = {gnt2, s2, busy2, y2};
  assign o1 = {gnt1, s1, busy1, y1};

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt4), .s(s4), .busy(busy4), .y(y4)
  );

  mux4_rr_arbiter #(.HOLD_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt2), .s(s2), .busy(busy2), .y(y2)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt1), .s(s1), .busy(busy1), .y(y1)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Reference model state. holder is -1 while idle. sel is the last
  // requester that was granted.
  typedef struct {
    int holder;
    int hcnt;
    int ptr;
    int sel;
  } model_t;

  model_t m4, m2, m1;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t tbl [20];

  function automatic model_t modelReset();
    model_t m;
    m.holder = -1;
    m.hcnt   = 0;
    m.ptr    = 0;
    m.sel    = 0;
    return m;
  endfunction

  // One clock edge of the reference model. It follows the arbitration rules
  // directly: the holder keeps the grant while it requests and has hold
  // budget left. Otherwise priority restarts just after the holder.
  function automatic model_t modelStep(model_t m, logic [3:0] r, int holdMax);
    int start;
    int winner;
    if (m.holder >= 0 && r[m.holder] && m.hcnt < holdMax) begin
      m.hcnt = m.hcnt + 1;
      return m;
    end
    if (m.holder >= 0) m.ptr = (m.holder + 1) % 4;
    start  = m.ptr;
    winner = -1;
    for (int k = 0; k < 4; k++) begin
      if (winner < 0 && r[(start + k) % 4]) winner = (start + k) % 4;
    end
    if (winner >= 0) begin
      m.holder = winner;
      m.sel    = winner;
      m.hcnt   = 1;
    end else begin
      m.holder = -1;
      m.hcnt   = 0;
    end
    return m;
  endfunction

  function automatic logic [7:0] modelOut(model_t m, logic [3:0] d);
    logic [3:0] g;
    logic       b;
    logic       yy;
    g  = 4'b0000;
    b  = 1'b0;
    yy = 1'b0;
    if (m.holder >= 0) begin
      g[m.holder] = 1'b1;
      b           = 1'b1;
      yy          = d[m.sel];
    end
    return {g, 2'(m.sel), b, yy};
  endfunction

  // Compare one packed {gnt, s, busy, y} observation against its expectation.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual gnt=%b s=%0d busy=%b y=%b required gnt=%b s=%0d busy=%b y=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Compare every instance against its reference model.
  task automatic checkAll(input string tag);
    checkOutput({tag, "_h4"}, o4, modelOut(m4, i));
    checkOutput({tag, "_h2"}, o2, modelOut(m2, i));
    checkOutput({tag, "_h1"}, o1, modelOut(m1, i));
  endtask

  // Drive inputs on the falling edge, clock once, advance the models, and
  // leave the caller just after the rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req = r;
    i   = d;
    @(posedge clk);
    m4 = modelStep(m4, r, 4);
    m2 = modelStep(m2, r, 2);
    m1 = modelStep(m1, r, 1);
    #1;
  endtask

  // Assert reset between edges and check the outputs clear immediately. Then
  // release reset with req=0 so the edge that follows leaves every instance
  // idle.
  task automatic applyReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m4 = modelReset();
    m2 = modelReset();
    m1 = modelReset();
    checkAll(tag);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;
  endtask

  initial begin
    // Directed vectors for the HOLD_MAX=4 instance. The starting point is the
    // reset state.
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'b0100, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[15] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[16] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[17] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[18] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[19] = '{4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst = 1'b1;
    req = 4'b1111;
    i   = 4'b1111;
    m4  = modelReset();
    m2  = modelReset();
    m1  = modelReset();
    #1;
    checkOutput("reset_h4", o4, 8'h00);
    checkOutput("reset_h2", o2, 8'h00);
    checkOutput("reset_h1", o1, 8'h00);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;

    // Table-driven directed vectors.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(tbl[k].req, tbl[k].din);
      checkOutput($sformatf("vec%0d", k), o4,
                  {tbl[k].gnt, tbl[k].s, tbl[k].busy, tbl[k].y});
      checkOutput($sformatf("vec%0d_h2", k), o2, modelOut(m2, i));
      checkOutput($sformatf("vec%0d_h1", k), o1, modelOut(m1, i));
    end

    // Asynchronous reset in the middle of a grant. After release, the first
    // arbitration must start again from requester 0.
    applyStimulus(4'b0010, 4'b1111);
    checkOutput("pre_rst_gnt", o4, {4'b0010, 2'd1, 1'b1, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_h4", o4, 8'h00);
    checkOutput("async_rst_h2", o2, 8'h00);
    m4 = modelReset();
    m2 = modelReset();
    m1 = modelReset();
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;
    applyStimulus(4'b1010, 4'b0000);
    checkOutput("post_rst_gnt", o4, {4'b0010, 2'd1, 1'b1, 1'b0});
    checkAll("post_rst");

    // Full load. HOLD_MAX=2 rotates every two cycles and HOLD_MAX=1 rotates
    // every cycle. Neither ever drops busy.
    applyReset("rst_fl");
    for (int k = 0; k < 10; k++) begin
      int idx2;
      int idx1;
      applyStimulus(4'b1111, 4'b0110);
      idx2 = (k / 2) % 4;
      idx1 = k % 4;
      checkOutput($sformatf("full_h2_%0d", k), o2,
                  {4'(1 << idx2), 2'(idx2), 1'b1, i[idx2]});
      checkOutput($sformatf("full_h1_%0d", k), o1,
                  {4'(1 << idx1), 2'(idx1), 1'b1, i[idx1]});
      checkOutput($sformatf("full_h4_%0d", k), o4, modelOut(m4, i));
    end

    // Randomized traffic against the reference model, with occasional resets.
    applyReset("rst_rand");
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(2) != 0) r = 4'($urandom);
      if ($urandom_range(9) == 0) r = 4'b0000;
      applyStimulus(r, 4'($urandom));
      checkAll($sformatf("rand%0d", n));
      if ($urandom_range(59) == 0) applyReset($sformatf("rand_rst%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
